// File: rtl/cnoc_pkg.sv
// -----------------------------------------------------------------------------
// cnoc_pkg
// Shared types and constants for the CNoC indication arbiter slice.
//   CNOC_WORD_W / CNOC_ID_W / CNOC_CNT_W : channel word, method id and word
//                                          count widths
//   cnoc_arb_state_t                     : arbiter message-serialiser states
//   cnoc_msg_word_t                      : channel word split into two 16-bit
//                                          fields (hi, lo)
//   idx_width()                          : index width for an N-entry table
//   clamp_nwords()                       : maps a raw word count into 1..max
// -----------------------------------------------------------------------------
package cnoc_pkg;

    localparam int CNOC_WORD_W = 32;
    localparam int CNOC_ID_W   = 16;
    localparam int CNOC_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PORTAL  = 2'd1,
        HEADER  = 2'd2,
        PAYLOAD = 2'd3
    } cnoc_arb_state_t;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } cnoc_msg_word_t;

    // At least one bit, so single-entry tables still get a legal index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero count still carries one payload word; oversize counts are cut
    // to what the capture buffer holds.
    function automatic logic [CNOC_CNT_W-1:0] clamp_nwords(
        input logic [CNOC_CNT_W-1:0] nwords,
        input int unsigned           max_words
    );
        if (nwords == '0)
            return CNOC_CNT_W'(1);
        else if (32'(nwords) > max_words)
            return CNOC_CNT_W'(max_words);
        else
            return nwords;
    endfunction

endpackage

// File: rtl/cnoc_rr_picker.sv
// -----------------------------------------------------------------------------
// cnoc_rr_picker
// Combinational round-robin first-one finder: scans i_req starting at
// i_rr_ptr and wrapping modulo NUM_PORTALS.
//   i_req     : request vector, one bit per source
//   i_rr_ptr  : first index to consider
//   o_found   : at least one request is set
//   o_index   : index of the first set request in scan order
// -----------------------------------------------------------------------------
module cnoc_rr_picker
    import cnoc_pkg::*;
#(
    parameter int NUM_PORTALS = 2,
    parameter int IDX_W       = idx_width(NUM_PORTALS)
) (
    input  logic [NUM_PORTALS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic                   o_found,
    output logic [IDX_W-1:0]       o_index
);

    int               w_sum;
    logic [IDX_W-1:0] w_cand;

    // NOTE: every output and temporary gets a default before the loop so
    // that no path leaves a value unassigned (which would infer a latch).
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_sum   = 0;
        w_cand  = '0;
        for (int j = 0; j < NUM_PORTALS; j++) begin
            w_sum = int'(i_rr_ptr) + j;
            if (w_sum >= NUM_PORTALS)
                w_sum = w_sum - NUM_PORTALS;
            w_cand = IDX_W'(w_sum);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_index = w_cand;
            end
        end
    end

endmodule

// File: rtl/cnoc_indication_arbiter.sv
// -----------------------------------------------------------------------------
// cnoc_indication_arbiter
// Shares the 32-bit CNoC indication channel among NUM_PORTALS sources with
// round-robin arbitration. A granted source's whole message is captured in
// one cycle, then sent as: portal word, header word, payload words. The
// channel stays with that message until its last word is dequeued.
//
// Ports
//   CLK, RST_N            : clock; synchronous active-low reset
//   src_valid[i]          : source i holds a complete message
//   src_id                : 16-bit method id per source (slice i = [16i+15:16i])
//   src_nwords            : 8-bit payload count per source
//   src_data              : MAX_WORDS x 32-bit payload per source
//   src_deq[i]            : one-cycle pulse, source i's message was captured
//   indications_first     : current channel word
//   RDY_indications_first : indications_first is valid
//   EN_indications_deq    : consumer takes the current word
//   indications_notEmpty  : same as RDY_indications_first
//   busy                  : a message is being serialised
//
// Build option: define CNOC_ARB_TRACE_EN to print every grant and every
// dequeued word in simulation.
// -----------------------------------------------------------------------------
module cnoc_indication_arbiter
    import cnoc_pkg::*;
#(
    parameter int NUM_PORTALS = 2,
    parameter int MAX_WORDS   = 4,
    parameter int PORTAL_BASE = 5
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic [NUM_PORTALS-1:0]                   src_valid,
    input  logic [CNOC_ID_W*NUM_PORTALS-1:0]         src_id,
    input  logic [CNOC_CNT_W*NUM_PORTALS-1:0]        src_nwords,
    input  logic [CNOC_WORD_W*MAX_WORDS*NUM_PORTALS-1:0] src_data,
    output logic [NUM_PORTALS-1:0]                   src_deq,
    output logic [CNOC_WORD_W-1:0]                   indications_first,
    output logic                                     RDY_indications_first,
    input  logic                                     EN_indications_deq,
    output logic                                     indications_notEmpty,
    output logic                                     busy
);

    localparam int IDX_W = idx_width(NUM_PORTALS);
    localparam int K_W   = idx_width(MAX_WORDS);

    // ---- per-source views of the flat input buses ---------------------------
    logic [CNOC_ID_W-1:0]   w_src_id     [NUM_PORTALS];
    logic [CNOC_CNT_W-1:0]  w_src_nwords [NUM_PORTALS];
    logic [CNOC_WORD_W-1:0] w_src_data   [NUM_PORTALS][MAX_WORDS];

    for (genvar p = 0; p < NUM_PORTALS; p++) begin : g_unpack
        assign w_src_id[p]     = src_id[p*CNOC_ID_W +: CNOC_ID_W];
        assign w_src_nwords[p] = src_nwords[p*CNOC_CNT_W +: CNOC_CNT_W];
        for (genvar k = 0; k < MAX_WORDS; k++) begin : g_word
            assign w_src_data[p][k] =
                src_data[(p*MAX_WORDS+k)*CNOC_WORD_W +: CNOC_WORD_W];
        end
    end

    // ---- state ---------------------------------------------------------------
    cnoc_arb_state_t        r_state;
    cnoc_arb_state_t        w_next_state;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_grant;
    logic [K_W-1:0]         r_cnt;
    logic [CNOC_ID_W-1:0]   r_id;
    logic [CNOC_CNT_W-1:0]  r_n;
    logic [CNOC_WORD_W-1:0] r_data [MAX_WORDS];

    // ---- combinational helpers -----------------------------------------------
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_capture;
    logic                   w_rdy;
    logic                   w_fire;
    logic                   w_last_word;
    cnoc_msg_word_t         w_word;
    logic [15:0]            w_portal_no;
    logic [15:0]            w_n_plus2;
    logic [15:0]            w_n_plus1;
    logic [IDX_W-1:0]       w_rr_next;

    cnoc_rr_picker #(
        .NUM_PORTALS (NUM_PORTALS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req    (src_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_index  (w_pick)
    );

    assign w_portal_no = 16'(PORTAL_BASE + int'(r_grant));
    assign w_n_plus2   = 16'(r_n) + 16'd2;
    assign w_n_plus1   = 16'(r_n) + 16'd1;
    assign w_last_word = (CNOC_CNT_W'(r_cnt) == (r_n - CNOC_CNT_W'(1)));
    assign w_rr_next   = (int'(r_grant) == NUM_PORTALS - 1) ? '0
                                                             : r_grant + IDX_W'(1);
    assign w_fire      = EN_indications_deq && w_rdy;

    // ---- FSM: next state and channel outputs ---------------------------------
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_rdy        = 1'b0;
        w_word       = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_capture    = 1'b1;
                    w_next_state = PORTAL;
                end
            end
            PORTAL: begin
                w_rdy     = 1'b1;
                w_word.hi = w_portal_no;
                w_word.lo = w_n_plus2;
                if (EN_indications_deq)
                    w_next_state = HEADER;
            end
            HEADER: begin
                w_rdy     = 1'b1;
                w_word.hi = r_id;
                w_word.lo = w_n_plus1;
                if (EN_indications_deq)
                    w_next_state = PAYLOAD;
            end
            PAYLOAD: begin
                w_rdy  = 1'b1;
                w_word = r_data[r_cnt];
                if (EN_indications_deq && w_last_word)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture)
                r_grant <= w_pick;
            if (r_state == PAYLOAD && w_fire) begin
                if (w_last_word) begin
                    r_cnt    <= '0;
                    r_rr_ptr <= w_rr_next;
                end else begin
                    r_cnt <= r_cnt + K_W'(1);
                end
            end
        end
    end

    // NOTE: the message buffer is deliberately not reset; it is only read in
    // PORTAL/HEADER/PAYLOAD, which are reachable only after a capture writes it.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_id <= w_src_id[w_pick];
            r_n  <= clamp_nwords(w_src_nwords[w_pick], MAX_WORDS);
            for (int k = 0; k < MAX_WORDS; k++)
                r_data[k] <= w_src_data[w_pick][k];
        end
    end

    // ---- outputs -------------------------------------------------------------
    // The grant pulse is suppressed while reset is held so no source loses a
    // message that the reset is about to discard.
    always_comb begin
        src_deq = '0;
        for (int i = 0; i < NUM_PORTALS; i++)
            src_deq[i] = RST_N && w_capture && (w_pick == IDX_W'(i));
    end

    assign indications_first     = w_word;
    assign RDY_indications_first = w_rdy;
    assign indications_notEmpty  = w_rdy;
    assign busy                  = (r_state != IDLE);

`ifdef CNOC_ARB_TRACE_EN
    always_ff @(posedge CLK) begin
        if (RST_N && w_capture)
            $display("CNOCARB: grant %d id %x words %d", w_pick, w_src_id[w_pick],
                     clamp_nwords(w_src_nwords[w_pick], MAX_WORDS));
        if (RST_N && w_fire)
            $display("CNOCARB: word %x", w_word);
    end
`else
    // Trace output compiled out.
`endif

endmodule

// File: tb/tb_cnoc_indication_arbiter.sv
module tb_cnoc_indication_arbiter;

    localparam int NP = 2;
    localparam int MW = 4;
    localparam int PB = 5;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [NP-1:0]        src_valid;
    logic [16*NP-1:0]     src_id;
    logic [8*NP-1:0]      src_nwords;
    logic [32*MW*NP-1:0]  src_data;
    logic [NP-1:0]        src_deq;
    logic [31:0]          indications_first;
    logic                 RDY_indications_first;
    logic                 EN_indications_deq;
    logic                 indications_notEmpty;
    logic                 busy;

    logic [15:0] t_id   [NP];
    logic [7:0]  t_nw   [NP];
    logic [31:0] t_data [NP][MW];

    always #5 CLK = ~CLK;

    always_comb begin
        src_id     = '0;
        src_nwords = '0;
        src_data   = '0;
        for (int p = 0; p < NP; p++) begin
            src_id[16*p +: 16]    = t_id[p];
            src_nwords[8*p +: 8]  = t_nw[p];
            for (int k = 0; k < MW; k++)
                src_data[(p*MW+k)*32 +: 32] = t_data[p][k];
        end
    end

    cnoc_indication_arbiter #(
        .NUM_PORTALS (NP),
        .MAX_WORDS   (MW),
        .PORTAL_BASE (PB)
    ) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .src_valid             (src_valid),
        .src_id                (src_id),
        .src_nwords            (src_nwords),
        .src_data              (src_data),
        .src_deq               (src_deq),
        .indications_first     (indications_first),
        .RDY_indications_first (RDY_indications_first),
        .EN_indications_deq    (EN_indications_deq),
        .indications_notEmpty  (indications_notEmpty),
        .busy                  (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: a queue of the words still owed to the consumer
    logic [31:0]   m_q [$];
    int            m_rr    = 0;
    int            m_grant = 0;
    bit            chk_en  = 1'b0;
    int            cyc     = 0;

    // observation logs used by the directed tests
    logic [31:0]   obs_words [$];
    int            obs_wcyc  [$];
    logic [NP-1:0] obs_deq   [$];

    always @(negedge CLK) begin
        logic [NP-1:0] e_deq;
        logic [31:0]   e_first;
        logic          e_rdy;
        int            pick;
        int            c;
        int            n;
        cyc++;
        if (chk_en) begin
            e_rdy   = (m_q.size() > 0);
            e_first = e_rdy ? m_q[0] : 32'h0;
            e_deq   = '0;
            pick    = -1;
            if (RST_N && !e_rdy) begin
                for (int j = 0; j < NP; j++) begin
                    c = (m_rr + j) % NP;
                    if (pick < 0 && ((src_valid >> c) & 1) != 0)
                        pick = c;
                end
            end
            if (pick >= 0)
                e_deq = NP'(1) << pick;

            check("rdy",      32'(RDY_indications_first), 32'(e_rdy));
            check("notEmpty", 32'(indications_notEmpty),  32'(e_rdy));
            check("busy",     32'(busy),                  32'(e_rdy));
            check("word",     indications_first,          e_first);
            check("src_deq",  32'(src_deq),               32'(e_deq));

            if (RST_N && RDY_indications_first && EN_indications_deq) begin
                obs_words.push_back(indications_first);
                obs_wcyc.push_back(cyc);
            end
            if (RST_N && src_deq != '0)
                obs_deq.push_back(src_deq);

            // advance the model to the state after the coming edge
            if (!RST_N) begin
                m_q.delete();
                m_rr = 0;
            end else if (e_rdy) begin
                if (EN_indications_deq) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0)
                        m_rr = (m_grant + 1) % NP;
                end
            end else if (pick >= 0) begin
                n = int'(t_nw[pick]);
                if (n == 0) n = 1;
                if (n > MW) n = MW;
                m_grant = pick;
                m_q.push_back({16'(PB + pick), 16'(n + 2)});
                m_q.push_back({t_id[pick], 16'(n + 1)});
                for (int k = 0; k < n; k++)
                    m_q.push_back(t_data[pick][k]);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic clear_logs();
        obs_words.delete();
        obs_wcyc.delete();
        obs_deq.delete();
    endtask

    logic [31:0] d0, d1, d2, d3, x0;
    logic [31:0] exp_w [$];

    initial begin
        RST_N              = 1'b0;
        EN_indications_deq = 1'b0;
        src_valid          = '0;
        for (int p = 0; p < NP; p++) begin
            t_id[p] = '0;
            t_nw[p] = '0;
            for (int k = 0; k < MW; k++) t_data[p][k] = '0;
        end

        // ---- reset values ---------------------------------------------------
        step();
        chk_en = 1'b1;
        step();
        @(negedge CLK);
        check("reset_rdy",     32'(RDY_indications_first), 32'h0);
        check("reset_busy",    32'(busy),                  32'h0);
        check("reset_word",    indications_first,          32'h0);
        check("reset_src_deq", 32'(src_deq),               32'h0);
        step();
        RST_N = 1'b1;

        // ---- single message -------------------------------------------------
        clear_logs();
        t_id[0] = 16'h0002; t_nw[0] = 8'd1; t_data[0][0] = 32'hDEADBEEF;
        src_valid = 2'b01; EN_indications_deq = 1'b1;
        @(negedge CLK);
        check("t1_deq_pulse", 32'(src_deq), 32'h1);
        step();
        src_valid = 2'b00;
        repeat (5) step();
        check("t1_count", 32'(obs_words.size()), 32'd3);
        if (obs_words.size() == 3) begin
            check("t1_portal",  obs_words[0], 32'h00050003);
            check("t1_header",  obs_words[1], 32'h00020002);
            check("t1_payload", obs_words[2], 32'hDEADBEEF);
            check("t1_consec",  32'(obs_wcyc[2] - obs_wcyc[0]), 32'd2);
        end
        @(negedge CLK);
        check("t1_rdy_after", 32'(RDY_indications_first), 32'h0);
        step();

        // ---- round robin ----------------------------------------------------
        do_reset();
        clear_logs();
        t_nw[0] = 8'd2; t_nw[1] = 8'd2;
        src_valid = 2'b11;
        repeat (22) step();
        src_valid = 2'b00;
        repeat (12) step();
        if (obs_deq.size() >= 4 && obs_words.size() >= 16) begin
            check("t2_grant0", 32'(obs_deq[0]), 32'h1);
            check("t2_grant1", 32'(obs_deq[1]), 32'h2);
            check("t2_grant2", 32'(obs_deq[2]), 32'h1);
            check("t2_grant3", 32'(obs_deq[3]), 32'h2);
            check("t2_portal0", obs_words[0],  32'h00050004);
            check("t2_portal1", obs_words[4],  32'h00060004);
            check("t2_portal2", obs_words[8],  32'h00050004);
            check("t2_portal3", obs_words[12], 32'h00060004);
        end else begin
            check("t2_enough_traffic", 32'(obs_words.size()), 32'd16);
        end

        // ---- backpressure during HEADER --------------------------------------
        do_reset();
        clear_logs();
        d0 = $urandom; d1 = $urandom;
        t_id[0] = 16'h1234; t_nw[0] = 8'd2; t_data[0][0] = d0; t_data[0][1] = d1;
        src_valid = 2'b01; EN_indications_deq = 1'b1;
        step();
        src_valid = 2'b00;
        step();
        repeat (5) begin
            EN_indications_deq = 1'b0;
            src_valid = NP'($urandom);
            t_id[0] = 16'($urandom); t_data[0][0] = $urandom; t_data[0][1] = $urandom;
            @(negedge CLK);
            check("t3_hold", indications_first, 32'h12340003);
            check("t3_busy", 32'(busy), 32'h1);
            step();
        end
        EN_indications_deq = 1'b1;
        src_valid = 2'b00;
        repeat (5) step();
        check("t3_count", 32'(obs_words.size()), 32'd4);
        if (obs_words.size() == 4) begin
            check("t3_w0", obs_words[0], 32'h00050004);
            check("t3_w1", obs_words[1], 32'h12340003);
            check("t3_w2", obs_words[2], d0);
            check("t3_w3", obs_words[3], d1);
        end

        // ---- nwords clamp ----------------------------------------------------
        do_reset();
        clear_logs();
        x0 = $urandom;
        t_id[1] = 16'h0007; t_nw[1] = 8'd0; t_data[1][0] = x0;
        src_valid = 2'b10;
        step();
        src_valid = 2'b00;
        repeat (5) step();
        d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
        t_id[0] = 16'h0005; t_nw[0] = 8'd9;
        t_data[0][0] = d0; t_data[0][1] = d1; t_data[0][2] = d2; t_data[0][3] = d3;
        src_valid = 2'b01;
        step();
        src_valid = 2'b00;
        repeat (9) step();
        exp_w = '{32'h00060003, 32'h00070002, x0,
                  32'h00050006, 32'h00050005, d0, d1, d2, d3};
        check("t4_count", 32'(obs_words.size()), 32'd9);
        if (obs_words.size() == 9)
            for (int i = 0; i < 9; i++)
                check($sformatf("t4_w%0d", i), obs_words[i], exp_w[i]);

        // ---- reset in the middle of PAYLOAD ----------------------------------
        do_reset();
        t_nw[0] = 8'd1;
        src_valid = 2'b01;
        step();
        src_valid = 2'b00;
        repeat (4) step();
        t_nw[1] = 8'd3;
        src_valid = 2'b10;
        step();
        src_valid = 2'b00;
        repeat (4) step();
        RST_N = 1'b0;
        src_valid = 2'b11;
        @(negedge CLK);
        check("t5_in_payload", 32'(RDY_indications_first), 32'h1);
        check("t5_no_deq_in_reset", 32'(src_deq), 32'h0);
        step();
        RST_N = 1'b1;
        @(negedge CLK);
        check("t5_rdy_cleared", 32'(RDY_indications_first), 32'h0);
        check("t5_busy_cleared", 32'(busy), 32'h0);
        check("t5_regrant_src0", 32'(src_deq), 32'h1);
        step();
        src_valid = 2'b00;
        repeat (8) step();

        // ---- EN_indications_deq while idle -----------------------------------
        repeat (6) begin
            EN_indications_deq = ~EN_indications_deq;
            @(negedge CLK);
            check("t6_no_deq", 32'(src_deq), 32'h0);
            check("t6_idle",   32'(busy),    32'h0);
            step();
        end

        // ---- randomized traffic against the model ----------------------------
        repeat (3000) begin
            src_valid = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                t_id[p] = 16'($urandom);
                t_nw[p] = 8'($urandom_range(0, 9));
                for (int k = 0; k < MW; k++) t_data[p][k] = $urandom;
            end
            EN_indications_deq = ($urandom_range(0, 9) < 7);
            RST_N = ($urandom_range(0, 199) != 0);
            step();
        end
        RST_N = 1'b1;
        src_valid = '0;
        EN_indications_deq = 1'b1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
